// File: rtl/vga_timing_gen.sv
// 800x525 VGA raster generator: DrawX/DrawY counters with registered, skew-free blank/hs/vs/frame_start.
// Optional frame counter behind VGA_TIMING_FRAME_CNT_EN; zero added latency, free-running, no backpressure.
module vga_timing_gen #(
   parameter int unsigned H_VISIBLE   = 640,
   parameter int unsigned H_FRONT     = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned V_VISIBLE   = 480,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter logic        SYNC_ACTIVE = 1'b0
) (
   input  logic        vga_clk,
   input  logic        reset_n,
   output logic [9:0]  DrawX,
   output logic [9:0]  DrawY,
   output logic        blank,
   output logic        hs,
   output logic        vs,
   output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0] frame_count
`endif
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_range_err
      $error("vga_timing_gen: H_TOTAL/V_TOTAL must be in 1..1024");
   end

   localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   // Window bounds are one bit wider so an end bound of exactly 1024 still compares correctly.
   localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
   localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] draw_x_q, draw_x_d;
   logic [9:0] draw_y_q, draw_y_d;
   logic       blank_q, blank_d;
   logic       hs_q, hs_d;
   logic       vs_q, vs_d;
   logic       frame_start_q, frame_start_d;
   logic [10:0] x_ext, y_ext;

   // Decodes look at the next counter value so they land on the same edge as the counters.
   always_comb begin
      draw_x_d = draw_x_q + 10'd1;
      draw_y_d = draw_y_q;
      if (draw_x_q == H_LAST) begin
         draw_x_d = '0;
         draw_y_d = (draw_y_q == V_LAST) ? '0 : draw_y_q + 10'd1;
      end
      x_ext         = {1'b0, draw_x_d};
      y_ext         = {1'b0, draw_y_d};
      blank_d       = (x_ext < H_VIS) && (y_ext < V_VIS);
      hs_d          = ((x_ext >= HS_BEG) && (x_ext < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_d          = ((y_ext >= VS_BEG) && (y_ext < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start_d = (draw_x_d == '0) && (draw_y_d == '0);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         draw_x_q      <= '0;
         draw_y_q      <= '0;
         blank_q       <= 1'b0;
         hs_q          <= ~SYNC_ACTIVE;
         vs_q          <= ~SYNC_ACTIVE;
         frame_start_q <= 1'b0;
      end else begin
         draw_x_q      <= draw_x_d;
         draw_y_q      <= draw_y_d;
         blank_q       <= blank_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign DrawX       = draw_x_q;
   assign DrawY       = draw_y_q;
   assign blank       = blank_q;
   assign hs          = hs_q;
   assign vs          = vs_q;
   assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_count_q, frame_count_d;

   always_comb begin
      frame_count_d = frame_count_q;
      if (frame_start_d) begin
         frame_count_d = frame_count_q + 16'd1;
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_count_q <= '0;
      end else begin
         frame_count_q <= frame_count_d;
      end
   end

   assign frame_count = frame_count_q;
`endif

endmodule
